// File: rtl/fb_write_scheduler_if.sv
// rtl/fb_write_scheduler_if.sv - client, clear-control and framebuffer write-port bundle for fb_write_scheduler
// Optional FB_BOUNDS_CHECK_EN adds the drop_count signal.
interface fb_write_scheduler_if #(
    parameter int COORD_W = 11
);
    logic               clear_start;
    logic               c0_req;
    logic [COORD_W-1:0] c0_x;
    logic [COORD_W-1:0] c0_y;
    logic               c0_color;
    logic               c0_grant;
    logic               c1_req;
    logic [COORD_W-1:0] c1_x;
    logic [COORD_W-1:0] c1_y;
    logic               c1_color;
    logic               c1_grant;
    logic [COORD_W-1:0] fb_x;
    logic [COORD_W-1:0] fb_y;
    logic               fb_color;
    logic               fb_write;
    logic               clearing;
    logic               clear_done;
`ifdef FB_BOUNDS_CHECK_EN
    logic [15:0]        drop_count;
`endif

    modport slave (
        input  clear_start,
        input  c0_req, c0_x, c0_y, c0_color,
        input  c1_req, c1_x, c1_y, c1_color,
        output c0_grant, c1_grant,
        output fb_x, fb_y, fb_color, fb_write,
        output clearing, clear_done
`ifdef FB_BOUNDS_CHECK_EN
        , output drop_count
`endif
    );

    modport master (
        output clear_start,
        output c0_req, c0_x, c0_y, c0_color,
        output c1_req, c1_x, c1_y, c1_color,
        input  c0_grant, c1_grant,
        input  fb_x, fb_y, fb_color, fb_write,
        input  clearing, clear_done
`ifdef FB_BOUNDS_CHECK_EN
        , input drop_count
`endif
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - framebuffer write-port scheduler: full-screen clear engine plus round-robin two-client arbiter
// Optional FB_BOUNDS_CHECK_EN: out-of-range client pixels are granted but not written, counted in drop_count.
module fb_write_scheduler #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int COORD_W = 11
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fb_write_scheduler_if.slave  bus
);
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    localparam logic [COORD_W-1:0] X_MAX    = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX    = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] START_NX = (WIDTH == 1) ? '0 : COORD_W'(1);
    localparam logic [COORD_W-1:0] START_NY = (WIDTH == 1) ? COORD_W'(1) : '0;
    localparam logic               START_LAST = (WIDTH == 1) && (HEIGHT == 1);

    state_t             r_state;
    logic [COORD_W-1:0] r_cx, r_cy;
    logic               r_last;
    logic               r_ptr;
    logic [COORD_W-1:0] r_fb_x, r_fb_y;
    logic               r_fb_color, r_fb_write, r_clearing, r_clear_done;

    logic               w_arb, w_g0, w_g1;
    logic [COORD_W-1:0] w_sel_x, w_sel_y, w_nx, w_ny;
    logic               w_sel_color, w_at_end;

    // Grants are combinational so a client can present its next pixel in the grant cycle.
    assign w_arb = reset_n && (r_state == ST_IDLE) && !bus.clear_start;
    assign w_g0  = w_arb && bus.c0_req && (!bus.c1_req || !r_ptr);
    assign w_g1  = w_arb && bus.c1_req && (!bus.c0_req ||  r_ptr);

    assign w_sel_x     = w_g1 ? bus.c1_x     : bus.c0_x;
    assign w_sel_y     = w_g1 ? bus.c1_y     : bus.c0_y;
    assign w_sel_color = w_g1 ? bus.c1_color : bus.c0_color;

    assign w_nx     = (r_cx == X_MAX) ? '0 : r_cx + 1'b1;
    assign w_ny     = (r_cx == X_MAX) ? r_cy + 1'b1 : r_cy;
    assign w_at_end = (r_cx == X_MAX) && (r_cy == Y_MAX);

`ifdef FB_BOUNDS_CHECK_EN
    logic [15:0] r_drop_count;
    logic        w_oob;
    assign w_oob = (w_sel_x > X_MAX) || (w_sel_y > Y_MAX);
    assign bus.drop_count = r_drop_count;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cx         <= '0;
            r_cy         <= '0;
            r_last       <= 1'b0;
            r_ptr        <= 1'b0;
            r_fb_x       <= '0;
            r_fb_y       <= '0;
            r_fb_color   <= 1'b0;
            r_fb_write   <= 1'b0;
            r_clearing   <= 1'b0;
            r_clear_done <= 1'b0;
`ifdef FB_BOUNDS_CHECK_EN
            r_drop_count <= '0;
`endif
        end else begin
            r_fb_write   <= 1'b0;
            r_clear_done <= 1'b0;
            if (bus.clear_start) begin
                // Pixel (0,0) is emitted straight away so clearing and fb_write rise together.
                r_state    <= ST_CLEAR;
                r_clearing <= 1'b1;
                r_fb_x     <= '0;
                r_fb_y     <= '0;
                r_fb_color <= 1'b0;
                r_fb_write <= 1'b1;
                r_cx       <= START_NX;
                r_cy       <= START_NY;
                r_last     <= START_LAST;
            end else begin
                case (r_state)
                    ST_CLEAR: begin
                        if (r_last) begin
                            r_state      <= ST_IDLE;
                            r_clearing   <= 1'b0;
                            r_clear_done <= 1'b1;
                            r_last       <= 1'b0;
                        end else begin
                            r_fb_x     <= r_cx;
                            r_fb_y     <= r_cy;
                            r_fb_color <= 1'b0;
                            r_fb_write <= 1'b1;
                            r_cx       <= w_nx;
                            r_cy       <= w_ny;
                            r_last     <= w_at_end;
                        end
                    end
                    default: begin
                        if (w_g0 || w_g1) begin
                            r_ptr <= w_g0;
`ifdef FB_BOUNDS_CHECK_EN
                            if (w_oob) begin
                                if (r_drop_count != 16'hFFFF)
                                    r_drop_count <= r_drop_count + 16'd1;
                            end else begin
                                r_fb_x     <= w_sel_x;
                                r_fb_y     <= w_sel_y;
                                r_fb_color <= w_sel_color;
                                r_fb_write <= 1'b1;
                            end
`else
                            r_fb_x     <= w_sel_x;
                            r_fb_y     <= w_sel_y;
                            r_fb_color <= w_sel_color;
                            r_fb_write <= 1'b1;
`endif
                        end
                    end
                endcase
            end
        end
    end

    assign bus.c0_grant   = w_g0;
    assign bus.c1_grant   = w_g1;
    assign bus.fb_x       = r_fb_x;
    assign bus.fb_y       = r_fb_y;
    assign bus.fb_color   = r_fb_color;
    assign bus.fb_write   = r_fb_write;
    assign bus.clearing   = r_clearing;
    assign bus.clear_done = r_clear_done;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb/tb_fb_write_scheduler.sv - scoreboard bench for fb_write_scheduler at WIDTH=4, HEIGHT=3
module tb_fb_write_scheduler;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 11;

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          c;
        logic          clr;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fb_write_scheduler_if #(.COORD_W(CW)) bus ();

    fb_write_scheduler #(.WIDTH(W), .HEIGHT(H), .COORD_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    exp_t q[$];
    exp_t m_e;
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;
    int   done_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic c, input logic clr);
        exp_t e;
        e.x = x; e.y = y; e.c = c; e.clr = clr;
        q.push_back(e);
    endtask

    task automatic push_clear(input int n);
        for (int i = 0; i < n; i++)
            push(CW'(i % W), CW'(i / W), 1'b0, 1'b1);
    endtask

    // One cycle of stimulus: expected writes are queued before the edge that produces them.
    task automatic cyc(input logic e0, input logic e1);
        if (e0) push(bus.c0_x, bus.c0_y, bus.c0_color, 1'b0);
        if (e1) push(bus.c1_x, bus.c1_y, bus.c1_color, 1'b0);
        @(negedge clk);
        chk("c0_grant", bus.c0_grant, e0);
        chk("c1_grant", bus.c1_grant, e1);
        @(posedge clk); #1;
    endtask

    task automatic cyc_done(input logic e0, input logic e1);
        if (e0) push(bus.c0_x, bus.c0_y, bus.c0_color, 1'b0);
        if (e1) push(bus.c1_x, bus.c1_y, bus.c1_color, 1'b0);
        @(negedge clk);
        chk("done_c0_grant", bus.c0_grant, e0);
        chk("done_c1_grant", bus.c1_grant, e1);
        chk("clear_done_pulse", bus.clear_done, 1'b1);
        chk("clearing_off", bus.clearing, 1'b0);
        chk("done_no_write", bus.fb_write, 1'b0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (bus.fb_write) begin
            if (q.size() == 0) begin
                chk("unexpected_write", bus.fb_write, 1'b0);
            end else begin
                m_e = q.pop_front();
                chk("fb_x", bus.fb_x, m_e.x);
                chk("fb_y", bus.fb_y, m_e.y);
                chk("fb_color", bus.fb_color, m_e.c);
                chk("clearing_during_write", bus.clearing, m_e.clr);
            end
        end
        if (bus.clear_done) done_seen++;
    end

    initial begin
        bus.clear_start = 0;
        bus.c0_req = 1; bus.c0_x = 5; bus.c0_y = 7; bus.c0_color = 1;
        bus.c1_req = 0; bus.c1_x = 2; bus.c1_y = 1; bus.c1_color = 0;

        // Reset state, with a request pending
        @(negedge clk);
        chk("rst_fb_x", bus.fb_x, 0);
        chk("rst_fb_y", bus.fb_y, 0);
        chk("rst_fb_write", bus.fb_write, 0);
        chk("rst_clearing", bus.clearing, 0);
        chk("rst_clear_done", bus.clear_done, 0);
        chk("rst_c0_grant", bus.c0_grant, 0);
        @(posedge clk); #1;
        bus.c0_req = 0;
        reset_n = 1;
        cyc(0, 0);

        // Full clear sweep
        bus.clear_start = 1;
        push_clear(W * H);
        done_exp++;
        cyc(0, 0);
        bus.clear_start = 0;
        repeat (W * H) cyc(0, 0);
        cyc_done(0, 0);
        @(negedge clk);
        chk("clear_done_single", bus.clear_done, 0);
        @(posedge clk); #1;

        // Client 0 streaming alone
        bus.c0_req = 1;
        repeat (4) cyc(1, 0);
        bus.c0_req = 0;
        cyc(0, 0);

        // Asynchronous reset restores the pointer to client 0
        reset_n = 0;
        #1;
        chk("async_rst_fb_x", bus.fb_x, 0);
        chk("async_rst_fb_color", bus.fb_color, 0);
        @(posedge clk); #1;
        reset_n = 1;

        // Both clients, then a clear mid-stream with requests held
        bus.c0_req = 1; bus.c1_req = 1;
        cyc(1, 0); cyc(0, 1); cyc(1, 0); cyc(0, 1); cyc(1, 0);
        bus.clear_start = 1;
        push_clear(W * H);
        done_exp++;
        cyc(0, 0);
        bus.clear_start = 0;
        repeat (W * H) cyc(0, 0);
        cyc_done(0, 1);
        cyc(1, 0);
        bus.c0_req = 0; bus.c1_req = 0;
        cyc(0, 0);

        // Restart while pixel (2,1) is on the bus
        bus.clear_start = 1;
        push_clear(7);
        cyc(0, 0);
        bus.clear_start = 0;
        repeat (6) cyc(0, 0);
        chk("restart_at_x", bus.fb_x, 2);
        chk("restart_at_y", bus.fb_y, 1);
        bus.clear_start = 1;
        push_clear(W * H);
        done_exp++;
        cyc(0, 0);
        bus.clear_start = 0;
        repeat (W * H) cyc(0, 0);
        cyc_done(0, 0);

        // Reset in the middle of a sweep
        bus.clear_start = 1;
        push_clear(4);
        cyc(0, 0);
        bus.clear_start = 0;
        repeat (4) cyc(0, 0);
        reset_n = 0;
        #1;
        chk("midclr_rst_write", bus.fb_write, 0);
        chk("midclr_rst_x", bus.fb_x, 0);
        chk("midclr_rst_clearing", bus.clearing, 0);
        repeat (2) cyc(0, 0);
        reset_n = 1;
        repeat (3) cyc(0, 0);

`ifdef FB_BOUNDS_CHECK_EN
        chk("drop_count_rst", bus.drop_count, 0);
        bus.c0_req = 1; bus.c0_x = 4; bus.c0_y = 0; bus.c0_color = 1;
        @(negedge clk);
        chk("oob_grant", bus.c0_grant, 1);
        @(posedge clk); #1;
        bus.c0_x = 3; bus.c0_y = 2;
        cyc(1, 0);
        bus.c0_req = 0;
        chk("drop_count_one", bus.drop_count, 1);
        cyc(0, 0);
`endif

        chk("done_count", done_seen, done_exp);
        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
